// File: rtl/regfile_ctx_stacker.sv
// Context save/restore engine: pushes A, B, C, IX to a downward-growing
// memory stack and pops them back into the register file in reverse order.
module regfile_ctx_stacker #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_RESET = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_save_req,
  input  logic              i_restore_req,
  input  logic              i_sp_load,
  input  logic [ADDR_W-1:0] i_sp_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic              o_unf,
  output logic [ADDR_W-1:0] o_sp_out,
  output logic              o_rf_ra1,
  output logic              o_rf_ra0,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic              o_rf_we,
  output logic              o_rf_wa1,
  output logic              o_rf_wa0,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wr,
  output logic              o_mem_rd,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack
);

  typedef enum logic [2:0] {IDLE, SAVE_WR, RST_RD, RST_WB, FIN} state_t;

  // Highest SP from which four pops stay inside the address space.
  localparam logic [ADDR_W-1:0] RST_MAX = {ADDR_W{1'b1}} - ADDR_W'(4);

  state_t            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic [1:0]        r_idx;
  logic [DATA_W-1:0] r_hold;
  logic [1:0]        r_rf_ra;
  logic [1:0]        r_rf_wa;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_wr;
  logic              r_mem_rd;
  logic              r_rf_we;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic              r_unf;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_sp       <= SP_RESET;
      r_idx      <= 2'd0;
      r_hold     <= '0;
      r_rf_ra    <= 2'd0;
      r_rf_wa    <= 2'd0;
      r_mem_addr <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_rf_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_save_req) begin
            if (r_sp >= ADDR_W'(3)) begin
              r_state    <= SAVE_WR;
              r_idx      <= 2'd0;
              r_rf_ra    <= 2'd0;
              r_mem_addr <= r_sp;
              r_mem_wr   <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (i_restore_req) begin
            if (r_sp <= RST_MAX) begin
              r_state    <= RST_RD;
              r_idx      <= 2'd3;
              r_mem_addr <= r_sp + ADDR_W'(1);
              r_mem_rd   <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_unf <= 1'b1;
            end
          end else if (i_sp_load) begin
            r_sp <= i_sp_in;
          end
        end
        SAVE_WR: begin
          if (i_mem_ack) begin
            r_sp <= r_sp - ADDR_W'(1);
            if (r_idx == 2'd3) begin
              r_state  <= FIN;
              r_mem_wr <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_rf_ra    <= r_idx + 2'd1;
              r_mem_addr <= r_sp - ADDR_W'(1);
            end
          end
        end
        RST_RD: begin
          if (i_mem_ack) begin
            r_hold   <= i_mem_rdata;
            r_sp     <= r_sp + ADDR_W'(1);
            r_state  <= RST_WB;
            r_mem_rd <= 1'b0;
            r_rf_we  <= 1'b1;
            r_rf_wa  <= r_idx;
          end
        end
        RST_WB: begin
          if (r_idx == 2'd0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_idx      <= r_idx - 2'd1;
            r_state    <= RST_RD;
            r_mem_addr <= r_sp + ADDR_W'(1);
            r_mem_rd   <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write data comes straight from the register file while a push is pending.
  assign o_mem_wdata = r_mem_wr ? i_rf_rdata : '0;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ovf       = r_ovf;
  assign o_unf       = r_unf;
  assign o_sp_out    = r_sp;
  assign o_rf_ra1    = r_rf_ra[1];
  assign o_rf_ra0    = r_rf_ra[0];
  assign o_rf_we     = r_rf_we;
  assign o_rf_wa1    = r_rf_wa[1];
  assign o_rf_wa0    = r_rf_wa[0];
  assign o_rf_wdata  = r_hold;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_rd    = r_mem_rd;

endmodule

// File: tb/tb_regfile_ctx_stacker.sv
// Bench for regfile_ctx_stacker: register-file and stack-memory models with
// configurable wait states, checked against stack push/pop expectations.
module tb_regfile_ctx_stacker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       saveReq = 1'b0;
  logic       restoreReq = 1'b0;
  logic       spLoad = 1'b0;
  logic [7:0] spIn = 8'h00;
  logic       spurAck = 1'b0;
  logic       busy, done, ovf, unf;
  logic [7:0] spOut;
  logic       ra1, ra0, rfWe, wa1, wa0;
  logic [7:0] rfWdata, rfRdata, memAddr, memWdata, memRdata;
  logic       memWr, memRd, memAck;

  logic [7:0] rf [4];
  logic [7:0] tbVals [4];
  logic       tbLoad = 1'b0;
  logic [7:0] mem [256];
  int         memWait = 0;
  int         waitCnt = 0;
  logic [15:0] wrLog [$];
  logic [9:0]  rfLog [$];
  int         rdCycles = 0;
  int         protoErr = 0;
  logic       prevPending = 1'b0;
  logic       prevReset = 1'b1;
  logic       prevWr, prevRd;
  logic [7:0] prevAddr, prevWdata;
  int         vectors = 0;
  int         miscompares = 0;

  regfile_ctx_stacker dut (
    .i_clk(clk), .i_reset(reset), .i_save_req(saveReq), .i_restore_req(restoreReq),
    .i_sp_load(spLoad), .i_sp_in(spIn), .o_busy(busy), .o_done(done), .o_ovf(ovf),
    .o_unf(unf), .o_sp_out(spOut), .o_rf_ra1(ra1), .o_rf_ra0(ra0), .i_rf_rdata(rfRdata),
    .o_rf_we(rfWe), .o_rf_wa1(wa1), .o_rf_wa0(wa0), .o_rf_wdata(rfWdata),
    .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .o_mem_wr(memWr), .o_mem_rd(memRd),
    .i_mem_rdata(memRdata), .i_mem_ack(memAck)
  );

  always #5 clk = ~clk;

  assign rfRdata  = rf[{ra1, ra0}];
  assign memRdata = mem[memAddr];
  assign memAck   = ((memWr | memRd) && (waitCnt >= memWait)) || spurAck;

  // Memory and register-file models, plus a log of every committed access.
  always @(posedge clk) begin
    if ((memWr | memRd) && !memAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
    if (memWr && memAck) begin
      mem[memAddr] <= memWdata;
      wrLog.push_back({memAddr, memWdata});
    end
    if (memRd) rdCycles <= rdCycles + 1;
    if (rfWe) begin
      rf[{wa1, wa0}] <= rfWdata;
      rfLog.push_back({wa1, wa0, rfWdata});
    end else if (tbLoad) begin
      for (int k = 0; k < 4; k++) rf[k] <= tbVals[k];
    end
  end

  // Bus protocol watch: pending strobes must hold steady, never both high.
  always @(posedge clk) begin
    if (prevPending && !prevReset) begin
      if (memWr !== prevWr || memRd !== prevRd || memAddr !== prevAddr ||
          (memWr && memWdata !== prevWdata)) protoErr <= protoErr + 1;
    end
    if (memWr && memRd) protoErr <= protoErr + 1;
    prevPending <= (memWr | memRd) && !memAck;
    prevReset   <= reset;
    prevWr      <= memWr;
    prevRd      <= memRd;
    prevAddr    <= memAddr;
    prevWdata   <= memWdata;
  end

  task automatic setRegs(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] ix);
    @(negedge clk);
    tbVals[0] = a; tbVals[1] = b; tbVals[2] = c; tbVals[3] = ix;
    tbLoad = 1'b1;
    @(negedge clk);
    tbLoad = 1'b0;
  endtask

  task automatic loadSp(input logic [7:0] v);
    @(negedge clk);
    spLoad = 1'b1; spIn = v;
    @(negedge clk);
    spLoad = 1'b0;
  endtask

  // Issues a request and counts cycles after the request edge until DONE.
  task automatic runOp(input logic doSave, input logic doRestore, input logic loadMid,
                       output int cycles);
    cycles = -1;
    @(negedge clk);
    saveReq = doSave; restoreReq = doRestore;
    @(negedge clk);
    saveReq = 1'b0; restoreReq = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (loadMid && c == 2) begin spLoad = 1'b1; spIn = 8'h40; end
      else spLoad = 1'b0;
      if (done) begin cycles = c; break; end
      @(negedge clk);
    end
    spLoad = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    int wb;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags busy=%b done=%b ovf=%b unf=%b want 0000", busy, done, ovf, unf); end
    vectors++; if (spOut !== 8'hFF) begin
      miscompares++; $display("FAIL reset_sp got %h want ff", spOut); end
    vectors++; if ({memWr, memRd, rfWe} !== 3'b000 || memAddr !== 8'h00 || memWdata !== 8'h00 ||
                   rfWdata !== 8'h00 || {ra1, ra0, wa1, wa0} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_outputs wr=%b rd=%b we=%b addr=%h wd=%h rfwd=%h sel=%b want all 0",
                              memWr, memRd, rfWe, memAddr, memWdata, rfWdata, {ra1, ra0, wa1, wa0}); end
    wb = wrLog.size();
    @(negedge clk); spurAck = 1'b1;
    repeat (2) @(negedge clk);
    spurAck = 1'b0;
    vectors++; if (busy !== 1'b0 || spOut !== 8'hFF || wrLog.size() !== wb) begin
      miscompares++; $display("FAIL idle_ack busy=%b sp=%h writes=%0d want 0 ff %0d", busy, spOut, wrLog.size(), wb); end
  endtask

  // Saves the four given values from startSp with the given wait count and checks the stack.
  task automatic test_save(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                           input logic [7:0] v3, input logic [7:0] startSp, input int w);
    logic [7:0] vals [4];
    int cyc, wb, eb;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    setRegs(v0, v1, v2, v3);
    loadSp(startSp);
    memWait = w;
    wb = wrLog.size(); eb = rfLog.size();
    runOp(1'b1, 1'b0, 1'b0, cyc);
    vectors++; if (cyc !== 5 + 4 * w) begin
      miscompares++; $display("FAIL save_latency got %0d want %0d", cyc, 5 + 4 * w); end
    vectors++; if (wrLog.size() !== wb + 4) begin
      miscompares++; $display("FAIL save_count got %0d want 4", wrLog.size() - wb); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (wrLog[wb + k] !== {8'(startSp - 8'(k)), vals[k]}) begin
        miscompares++; $display("FAIL save_push%0d got %h want %h", k, wrLog[wb + k], {8'(startSp - 8'(k)), vals[k]}); end
    end
    vectors++; if (spOut !== 8'(startSp - 8'd4)) begin
      miscompares++; $display("FAIL save_sp got %h want %h", spOut, 8'(startSp - 8'd4)); end
    vectors++; if (rfLog.size() !== eb || busy !== 1'b0) begin
      miscompares++; $display("FAIL save_side rfwrites=%0d busy=%b want 0 0", rfLog.size() - eb, busy); end
  endtask

  // Restores from the current SP and expects IX, C, B, A in that order.
  task automatic test_restore(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                              input logic [7:0] v3, input int w);
    logic [7:0] vals [4];
    logic [7:0] sp0;
    int cyc, eb, wb;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    setRegs(8'h00, 8'h00, 8'h00, 8'h00);
    memWait = w;
    sp0 = spOut;
    eb = rfLog.size(); wb = wrLog.size();
    runOp(1'b0, 1'b1, 1'b0, cyc);
    vectors++; if (cyc !== 9 + 4 * w) begin
      miscompares++; $display("FAIL restore_latency got %0d want %0d", cyc, 9 + 4 * w); end
    vectors++; if (rfLog.size() !== eb + 4 || wrLog.size() !== wb) begin
      miscompares++; $display("FAIL restore_count rf=%0d mem=%0d want 4 0", rfLog.size() - eb, wrLog.size() - wb); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (rfLog[eb + k] !== {2'(3 - k), vals[3 - k]}) begin
        miscompares++; $display("FAIL restore_pop%0d got %h want %h", k, rfLog[eb + k], {2'(3 - k), vals[3 - k]}); end
    end
    vectors++; if (spOut !== 8'(sp0 + 8'd4)) begin
      miscompares++; $display("FAIL restore_sp got %h want %h", spOut, 8'(sp0 + 8'd4)); end
    vectors++; if (rf[0] !== v0 || rf[1] !== v1 || rf[2] !== v2 || rf[3] !== v3) begin
      miscompares++; $display("FAIL restore_regs got %h %h %h %h want %h %h %h %h",
                              rf[0], rf[1], rf[2], rf[3], v0, v1, v2, v3); end
  endtask

  task automatic test_random;
    logic [7:0] a, b, c, ix, sp;
    int w;
    for (int it = 0; it < 4; it++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); ix = 8'($urandom);
      sp = 8'($urandom_range(3, 255));
      w = $urandom_range(0, 2);
      test_save(a, b, c, ix, sp, w);
      test_restore(a, b, c, ix, $urandom_range(0, 2));
    end
  endtask

  task automatic test_bounds;
    int rb, wb, cyc;
    loadSp(8'h02);
    wb = wrLog.size();
    @(negedge clk); saveReq = 1'b1;
    @(negedge clk); saveReq = 1'b0;
    vectors++; if (ovf !== 1'b1 || busy !== 1'b0 || memWr !== 1'b0) begin
      miscompares++; $display("FAIL ovf_pulse ovf=%b busy=%b wr=%b want 1 0 0", ovf, busy, memWr); end
    @(negedge clk);
    vectors++; if (ovf !== 1'b0 || spOut !== 8'h02 || wrLog.size() !== wb) begin
      miscompares++; $display("FAIL ovf_after ovf=%b sp=%h writes=%0d want 0 02 0", ovf, spOut, wrLog.size() - wb); end
    loadSp(8'hFC);
    rb = rdCycles;
    @(negedge clk); restoreReq = 1'b1;
    @(negedge clk); restoreReq = 1'b0;
    vectors++; if (unf !== 1'b1 || busy !== 1'b0 || memRd !== 1'b0) begin
      miscompares++; $display("FAIL unf_pulse unf=%b busy=%b rd=%b want 1 0 0", unf, busy, memRd); end
    @(negedge clk);
    vectors++; if (unf !== 1'b0 || spOut !== 8'hFC || rdCycles !== rb) begin
      miscompares++; $display("FAIL unf_after unf=%b sp=%h reads=%0d want 0 fc 0", unf, spOut, rdCycles - rb); end
    test_save(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h03, 0);
    loadSp(8'hFB);
    memWait = 0;
    runOp(1'b0, 1'b1, 1'b0, cyc);
    vectors++; if (cyc !== 9 || spOut !== 8'hFF) begin
      miscompares++; $display("FAIL restore_edge cycles=%0d sp=%h want 9 ff", cyc, spOut); end
  endtask

  task automatic test_simultaneous;
    int cyc, rb, wb;
    setRegs(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    loadSp(8'hFF);
    memWait = 0;
    rb = rdCycles; wb = wrLog.size();
    runOp(1'b1, 1'b1, 1'b0, cyc);
    vectors++; if (cyc !== 5 || wrLog.size() !== wb + 4 || rdCycles !== rb || spOut !== 8'hFB) begin
      miscompares++; $display("FAIL both_req cycles=%0d writes=%0d reads=%0d sp=%h want 5 4 0 fb",
                              cyc, wrLog.size() - wb, rdCycles - rb, spOut); end
    loadSp(8'hFF);
    runOp(1'b1, 1'b0, 1'b1, cyc);
    vectors++; if (cyc !== 5 || spOut !== 8'hFB) begin
      miscompares++; $display("FAIL load_busy cycles=%0d sp=%h want 5 fb", cyc, spOut); end
  endtask

  task automatic test_reset_mid;
    int cyc, eb, wb;
    logic found;
    test_save(8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 0);
    setRegs(8'h00, 8'h00, 8'h00, 8'h00);
    memWait = 2;
    eb = rfLog.size();
    @(negedge clk); restoreReq = 1'b1;
    @(negedge clk); restoreReq = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rfLog.size() == eb + 1 && memRd) begin found = 1'b1; break; end
      @(negedge clk);
    end
    vectors++; if (found !== 1'b1) begin
      miscompares++; $display("FAIL second_read_reached got %b want 1", found); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || spOut !== 8'hFF || {memWr, memRd, rfWe} !== 3'b000) begin
      miscompares++; $display("FAIL midreset busy=%b sp=%h strobes=%b want 0 ff 000", busy, spOut, {memWr, memRd, rfWe}); end
    vectors++; if (rf[3] !== 8'h44 || rf[2] !== 8'h00) begin
      miscompares++; $display("FAIL midreset_regs ix=%h c=%h want 44 00", rf[3], rf[2]); end
    reset = 1'b0;
    memWait = 0;
    wb = wrLog.size();
    runOp(1'b1, 1'b0, 1'b0, cyc);
    vectors++; if (cyc !== 5 || spOut !== 8'hFB || wrLog.size() !== wb + 4) begin
      miscompares++; $display("FAIL after_reset_save cycles=%0d sp=%h writes=%0d want 5 fb 4", cyc, spOut, wrLog.size() - wb); end
    vectors++; if (wrLog[wb] !== 16'hFF00 || wrLog[wb + 3] !== 16'hFC44) begin
      miscompares++; $display("FAIL after_reset_data got %h %h want ff00 fc44", wrLog[wb], wrLog[wb + 3]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_save(8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 0);
    test_restore(8'h11, 8'h22, 8'h33, 8'h44, 0);
    test_save(8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 2);
    test_restore(8'h11, 8'h22, 8'h33, 8'h44, 1);
    test_random();
    test_bounds();
    test_simultaneous();
    test_reset_mid();
    vectors++; if (protoErr !== 0) begin
      miscompares++; $display("FAIL bus_protocol violations=%0d want 0", protoErr); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
